// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter sharing one synchronous data RAM between CPU and loader
module ram_arbiter #(
  parameter int RamWords  = 256,
  parameter bit FixedPrio = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,

  input  logic                        p0_valid_i,
  input  logic [31:0]                 p0_addr_i,
  input  logic [31:0]                 p0_wdata_i,
  input  logic [3:0]                  p0_wstrb_i,
  output logic [31:0]                 p0_rdata_o,
  output logic                        p0_ready_o,

  input  logic                        p1_valid_i,
  input  logic [31:0]                 p1_addr_i,
  input  logic [31:0]                 p1_wdata_i,
  input  logic [3:0]                  p1_wstrb_i,
  output logic [31:0]                 p1_rdata_o,
  output logic                        p1_ready_o,

  output logic [$clog2(RamWords)-1:0] ram_addr_o,
  output logic [31:0]                 ram_wdata_o,
  output logic [3:0]                  ram_wen_o,
  input  logic [31:0]                 ram_rd_data_i,

  output logic                        err_o
);

  localparam int AW = $clog2(RamWords);
  // 33 bits so the byte limit cannot wrap even for a full 4 GiB window
  localparam logic [32:0] WinLimit = 33'(RamWords) << 2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e state_q;
  logic   winner_q;   // 0 = port 0, 1 = port 1
  logic   oow_q;      // granted access was outside the RAM window
  logic   last_q;     // last granted port, drives round-robin

  logic        any_req;
  logic        grant_p1_d;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_wstrb;
  logic        in_win;
  logic        resp;

  assign any_req = p0_valid_i | p1_valid_i;

  // Winner selection: lone requester wins; on contention fixed priority or the port not served last
  always_comb begin
    grant_p1_d = 1'b0;
    if (p0_valid_i && p1_valid_i) begin
      if (FixedPrio) grant_p1_d = 1'b1;
      else           grant_p1_d = ~last_q;
    end else if (p1_valid_i) begin
      grant_p1_d = 1'b1;
    end
  end

  // With no request the grant defaults to port 0, so the RAM bus follows port 0 when idle
  assign win_addr  = grant_p1_d ? p1_addr_i  : p0_addr_i;
  assign win_wdata = grant_p1_d ? p1_wdata_i : p0_wdata_i;
  assign win_wstrb = grant_p1_d ? p1_wstrb_i : p0_wstrb_i;
  assign in_win    = {1'b0, win_addr} < WinLimit;

  assign ram_addr_o  = win_addr[AW+1:2];
  assign ram_wdata_o = win_wdata;
  // Strobe only in the request cycle, only in-window, and never while reset is held
  assign ram_wen_o   = (reset_ni && (state_q == IDLE) && any_req && in_win) ? win_wstrb : 4'b0000;

  // Request/response FSM: latch grant in IDLE, complete in RESP, always return to IDLE
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      oow_q    <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q  <= RESP;
            winner_q <= grant_p1_d;
            oow_q    <= ~in_win;
            last_q   <= grant_p1_d;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion decode; all terms come from registered state so reset clears them at once
  assign resp       = (state_q == RESP);
  assign p0_ready_o = resp & ~winner_q;
  assign p1_ready_o = resp &  winner_q;
  assign err_o      = resp &  oow_q;
  assign p0_rdata_o = (p0_ready_o && !oow_q) ? ram_rd_data_i : 32'h0;
  assign p1_rdata_o = (p1_ready_o && !oow_q) ? ram_rd_data_i : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed table-driven bench for ram_arbiter
module tb_ram_arbiter;

  logic        clk;
  logic        reset_ni;

  logic        p0_valid, p1_valid;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rd;
  logic        err;

  logic        fp0_valid, fp1_valid;
  logic [31:0] fp0_rdata, fp1_rdata;
  logic        fp0_ready, fp1_ready;
  logic [7:0]  fp_ram_addr;
  logic [31:0] fp_ram_wdata;
  logic [3:0]  fp_ram_wen;
  logic [31:0] fp_rd;
  logic        fp_err;

  logic [31:0] mem [256];

  int checks;
  int failures;

  typedef struct {
    logic        p0v;
    logic [31:0] p0a;
    logic [31:0] p0d;
    logic [3:0]  p0s;
    logic        p1v;
    logic [31:0] p1a;
    logic [31:0] p1d;
    logic [3:0]  p1s;
    logic [3:0]  wen;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        r0;
    logic        r1;
    logic        er;
    logic        chkd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [17];

  ram_arbiter #(.RamWords(256), .FixedPrio(1'b0)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .p0_valid_i(p0_valid), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_wstrb_i(p0_wstrb),
    .p0_rdata_o(p0_rdata), .p0_ready_o(p0_ready),
    .p1_valid_i(p1_valid), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_wstrb_i(p1_wstrb),
    .p1_rdata_o(p1_rdata), .p1_ready_o(p1_ready),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wen_o(ram_wen),
    .ram_rd_data_i(ram_rd), .err_o(err)
  );

  ram_arbiter #(.RamWords(256), .FixedPrio(1'b1)) dut_fp (
    .clk_i(clk), .reset_ni(reset_ni),
    .p0_valid_i(fp0_valid), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_wstrb_i(p0_wstrb),
    .p0_rdata_o(fp0_rdata), .p0_ready_o(fp0_ready),
    .p1_valid_i(fp1_valid), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_wstrb_i(p1_wstrb),
    .p1_rdata_o(fp1_rdata), .p1_ready_o(fp1_ready),
    .ram_addr_o(fp_ram_addr), .ram_wdata_o(fp_ram_wdata), .ram_wen_o(fp_ram_wen),
    .ram_rd_data_i(fp_rd), .err_o(fp_err)
  );

  assign fp_rd = 32'hA5A5_0001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: byte-enabled write, registered read one cycle after address
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    ram_rd <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    p0_valid = v.p0v; p0_addr = v.p0a; p0_wdata = v.p0d; p0_wstrb = v.p0s;
    p1_valid = v.p1v; p1_addr = v.p1a; p1_wdata = v.p1d; p1_wstrb = v.p1s;
    #1;
    chk($sformatf("v%0d_wen", i),   {28'h0, ram_wen},   {28'h0, v.wen});
    chk($sformatf("v%0d_addr", i),  {24'h0, ram_addr},  {24'h0, v.addr});
    chk($sformatf("v%0d_wdata", i), ram_wdata,          v.wdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d_ready0", i), {31'h0, p0_ready}, {31'h0, v.r0});
    chk($sformatf("v%0d_ready1", i), {31'h0, p1_ready}, {31'h0, v.r1});
    chk($sformatf("v%0d_err", i),    {31'h0, err},      {31'h0, v.er});
    chk($sformatf("v%0d_resp_wen", i), {28'h0, ram_wen}, 32'h0);
    if (!v.r0) chk($sformatf("v%0d_rdata0_idle", i), p0_rdata, 32'h0);
    if (!v.r1) chk($sformatf("v%0d_rdata1_idle", i), p1_rdata, 32'h0);
    if (v.chkd && v.r0) chk($sformatf("v%0d_rdata0", i), p0_rdata, v.rdata);
    if (v.chkd && v.r1) chk($sformatf("v%0d_rdata1", i), p1_rdata, v.rdata);
    @(posedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;

    //        p0v  p0a           p0d           p0s   p1v  p1a           p1d           p1s   wen   addr   wdata         r0 r1 er chk rdata
    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0,   32'h0,        4'h0, 4'hF, 8'h04, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h10,  32'h0,        4'h0, 1'b0, 32'h0,   32'h0,        4'h0, 4'h0, 8'h04, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h20,  32'h11223344, 4'hF, 4'hF, 8'h08, 32'h11223344, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h20,  32'h000000AA, 4'h1, 4'h1, 8'h08, 32'h000000AA, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h20,  32'h0,        4'h0, 1'b0, 32'h0,   32'h0,        4'h0, 4'h0, 8'h08, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h112233AA};
    vecs[5]  = '{1'b1, 32'h0,   32'h55AA55AA, 4'hF, 1'b0, 32'h0,   32'h0,        4'h0, 4'hF, 8'h00, 32'h55AA55AA, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,   32'h0,        4'h0, 4'h0, 8'h00, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h400, 32'h0,        4'h0, 1'b0, 32'h0,   32'h0,        4'h0, 4'h0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,   32'h0,        4'h0, 4'h0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h55AA55AA};
    vecs[9]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'hFFFFFFFC, 32'h0,   4'h0, 4'h0, 8'hFF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 4'hF, 8'hFF, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h3FC, 32'h0,        4'h0, 1'b0, 32'h0,   32'h0,        4'h0, 4'h0, 8'hFF, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[12] = '{1'b1, 32'h40,  32'h00000001, 4'hF, 1'b1, 32'h40,  32'h00000002, 4'hF, 4'hF, 8'h10, 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'h40,  32'h00000001, 4'hF, 1'b0, 32'h0,   32'h0,        4'h0, 4'hF, 8'h10, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h40,  32'h0,        4'h0, 4'h0, 8'h10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h00000001};
    vecs[15] = '{1'b1, 32'h10,  32'h0,        4'h0, 1'b1, 32'h20,  32'h0,        4'h0, 4'h0, 8'h04, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[16] = '{1'b1, 32'h10,  32'h0,        4'h0, 1'b1, 32'h20,  32'h0,        4'h0, 4'h0, 8'h08, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h112233AA};

    // Reset state, with a pending write presented to prove strobes stay off
    reset_ni  = 1'b0;
    p0_valid  = 1'b1; p0_addr = 32'h10; p0_wdata = 32'h12345678; p0_wstrb = 4'hF;
    p1_valid  = 1'b0; p1_addr = 32'h0;  p1_wdata = 32'h0;        p1_wstrb = 4'h0;
    fp0_valid = 1'b0; fp1_valid = 1'b0;
    #12;
    chk("rst_wen",    {28'h0, ram_wen},   32'h0);
    chk("rst_addr",   {24'h0, ram_addr},  32'h4);
    chk("rst_ready0", {31'h0, p0_ready},  32'h0);
    chk("rst_ready1", {31'h0, p1_ready},  32'h0);
    chk("rst_rdata0", p0_rdata,           32'h0);
    chk("rst_rdata1", p1_rdata,           32'h0);
    chk("rst_err",    {31'h0, err},       32'h0);
    p0_valid = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;

    for (int i = 0; i < 17; i++) apply_vec(i);

    // Round-robin contention from reset: grants 0,1,0,1 with readys two cycles apart
    @(negedge clk);
    reset_ni = 1'b0;
    p0_valid = 1'b1; p0_addr = 32'h10; p0_wstrb = 4'h0;
    p1_valid = 1'b1; p1_addr = 32'h20; p1_wstrb = 4'h0;
    @(negedge clk);
    reset_ni = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rr%0d_ready0", k), {31'h0, p0_ready}, {31'h0, (k % 4) == 0});
      chk($sformatf("rr%0d_ready1", k), {31'h0, p1_ready}, {31'h0, (k % 4) == 2});
      if ((k % 4) == 0) chk($sformatf("rr%0d_rdata0", k), p0_rdata, 32'hDEADBEEF);
      if ((k % 4) == 2) chk($sformatf("rr%0d_rdata1", k), p1_rdata, 32'h112233AA);
    end
    p0_valid = 1'b0;
    p1_valid = 1'b0;

    // Fixed priority: port 1 served every time until it drops valid, then port 0
    @(negedge clk);
    fp0_valid = 1'b1;
    fp1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("fp%0d_ready0", k), {31'h0, fp0_ready}, {31'h0, k == 6});
      chk($sformatf("fp%0d_ready1", k), {31'h0, fp1_ready}, {31'h0, (k == 0) || (k == 2) || (k == 4)});
      if (k == 0) chk("fp0_rdata1", fp1_rdata, 32'hA5A50001);
      if (k == 5) fp1_valid = 1'b0;
    end
    fp0_valid = 1'b0;

    // Reset during RESP drops ready at once; afterwards port 0 wins first contention
    @(negedge clk);
    p0_valid = 1'b1; p0_addr = 32'h10; p0_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("rr_pre_ready0", {31'h0, p0_ready}, 32'h1);
    reset_ni = 1'b0;
    #1;
    chk("rst_resp_ready0", {31'h0, p0_ready}, 32'h0);
    chk("rst_resp_rdata0", p0_rdata,          32'h0);
    p1_valid = 1'b1; p1_addr = 32'h20;
    @(negedge clk);
    reset_ni = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready0", {31'h0, p0_ready}, 32'h1);
    chk("post_rst_ready1", {31'h0, p1_ready}, 32'h0);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port synchronous data RAM (`ram_1r1w_sync`, 32-bit words) between the picorv32 native memory bus and a second bus master (UART loader/debug port). It decodes the RAM window and serializes accesses with round-robin or fixed priority. For each accepted request it drives the RAM write strobes and address for exactly one cycle. It returns read data with a one-cycle ready pulse to the winning port only.

## Interface
- `RamWords`, 256, RAM depth in 32-bit words; window is byte addresses `[0, 4*RamWords)`.
- `FixedPrio`, 0, 0 = round-robin, 1 = port 1 always wins contention.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `reset_ni`  in  1  reset, asynchronous, active-low.
- `p0_valid_i`  in  1  port 0 (CPU) request.
- `p0_addr_i`  in  32  byte address.
- `p0_wdata_i`  in  32  write data.
- `p0_wstrb_i`  in  4  byte write strobes; 0 = read.
- `p0_rdata_o`  out  32  read data, valid when `p0_ready_o`.
- `p0_ready_o`  out  1  one-cycle completion pulse.
- `p1_valid_i`, `p1_addr_i`, `p1_wdata_i`, `p1_wstrb_i`, `p1_rdata_o`, `p1_ready_o`: same as port 0, for port 1 (loader).
- `ram_addr_o`  out  $clog2(RamWords)  word address to RAM.
- `ram_wdata_o`  out  32  write data to RAM.
- `ram_wen_o`  out  4  byte write enables to RAM.
- `ram_rd_data_i`  in  32  RAM read data, one cycle after address.
- `err_o`  out  1  one-cycle pulse, coincident with ready, for an out-of-window access.

## Operation
- FSM states: IDLE, RESP.
- In IDLE with no valid request:
  - `ram_wen_o` = 0.
  - `ram_addr_o`/`ram_wdata_o` follow port 0 (don't-care).
- In IDLE with any valid request:
  - Pick a winner (arbitration below).
  - Drive, combinationally in the same cycle: `ram_addr_o` = winner addr[$clog2(RamWords)+1:2], `ram_wdata_o` = winner wdata.
  - `ram_wen_o` = winner wstrb if the address is in the window, else 0.
  - Register the winner index and an out-of-window flag.
  - Go to RESP.
- In RESP:
  - Assert the winner's `ready_o` for exactly one cycle.
  - Winner `rdata_o` = `ram_rd_data_i`, or 0 if out-of-window.
  - `err_o` = out-of-window flag.
  - `ram_wen_o` = 0.
  - Return to IDLE unconditionally.
- Non-winner ports: `ready_o` = 0, `rdata_o` = 0.
- Arbitration:
  - Single requester wins.
  - With `FixedPrio` = 1, port 1 wins contention.
  - Otherwise round-robin: a `last` register records the last winner, and the other port wins contention; `last` updates on every grant.
- Requesters hold valid/addr/wdata/wstrb stable until they see ready (picorv32 native protocol).
- Writes complete with ready and `rdata_o` = RAM output; the value is don't-care to masters.
- Address bits [1:0] are ignored. Address bits above the window index participate only in the window check (`addr < 4*RamWords`, 32-bit unsigned compare).

## Timing
- Request seen in IDLE at cycle N: RAM strobed in cycle N; ready and rdata in cycle N+1.
- Maximum throughput: one access per 2 cycles. A loser waits at least 2 cycles.
- A master that drops valid the cycle after ready is never double-served, because IDLE re-samples valid.
- Reset values (asynchronous, while `reset_ni` = 0):
  - state = IDLE, `last` = 1 (port 0 wins first contention).
  - Both `ready_o` = 0, both `rdata_o` = 0, `err_o` = 0, `ram_wen_o` = 0.
- Reset asserted in RESP: the pending ready is dropped. Reset asserted in IDLE during a write: the write may or may not land; no ready is issued.
- Simultaneous requests to the same address: serialized strictly by arbitration order; the second reader sees the first writer's data.

## Test plan
- Port 0 write 0xDEADBEEF to 0x10 with wstrb 4'b1111, then read 0x10.
  - Write: `ram_wen_o` = 4'hF and `ram_addr_o` = 4 in the request cycle; `p0_ready_o` next cycle.
  - Read: `p0_rdata_o` = 0xDEADBEEF.
- Port 1 write 0x000000AA to 0x20 with wstrb 4'b0001 over existing 0x11223344; port 0 reads 0x20 → 0x112233AA.
- Both ports hold read requests continuously, `FixedPrio` = 0, from reset.
  - Grants alternate 0,1,0,1; each ready is one cycle; readys are spaced 2 cycles.
- Same contention with `FixedPrio` = 1: port 1 is granted every transaction while it requests; port 0 is served only after port 1 drops valid.
- Port 0 write to 0x400 (RamWords = 256):
  - `ram_wen_o` stays 0.
  - Next cycle: `p0_ready_o` = 1, `err_o` = 1.
  - A read of 0x400 returns 0, and RAM word 0 is unchanged.
- Assert `reset_ni` low during RESP: `p0_ready_o` = 0 immediately (asynchronous). After release with both requesting: port 0 is granted first.
